// File: rtl/bcd_field_counter.sv
// Multi-digit BCD time/date field counter with up/down count, runtime max, checked load and optional clamp.
// Latency: value_o/load_err_o register in 1 cycle, ovf_o/unf_o/at_*_o are combinational; backpressure: none.
module bcd_field_counter #(
    parameter int DIGITS = 2,
    parameter int MIN    = 0,
    parameter int MAX    = 59,
    parameter int CLAMP  = 0,
    localparam int WIDTH = 4*DIGITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             ovf_o,
    output logic             unf_o,
    input  logic             dyn_max_en_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             load_err_o,
    output logic [WIDTH-1:0] value_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    function automatic logic [WIDTH-1:0] to_bcd(input int n);
        logic [WIDTH-1:0] r;
        int               v;
        r = '0;
        v = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [WIDTH-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Compare through a function so constant MIN = 0 does not trip unsigned-compare lint.
    function automatic logic ge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return a >= b;
    endfunction

    function automatic logic [WIDTH-1:0] bcd_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] bcd_dec(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] MIN_BCD = to_bcd(MIN);
    localparam logic [WIDTH-1:0] MAX_BCD = to_bcd(MAX);

    logic [WIDTH-1:0] value_q, value_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] emax;
    logic             dyn_max_ok;
    logic             load_ok;
    logic             step_up;
    logic             step_dn;

    // A malformed or below-MIN runtime max falls back to the static MAX.
    assign dyn_max_ok = dyn_max_en_i && bcd_ok(max_i) && ge(max_i, MIN_BCD);
    assign emax       = (dyn_max_ok && !ge(max_i, MAX_BCD)) ? max_i : MAX_BCD;

    assign at_max_o = ge(value_q, emax);
    assign at_min_o = ge(MIN_BCD, value_q);

    assign step_up = inc_i && !dec_i && !load_i;
    assign step_dn = dec_i && !inc_i && !load_i;
    assign ovf_o   = step_up && at_max_o;
    assign unf_o   = step_dn && at_min_o;

    assign load_ok = bcd_ok(load_value_i) && ge(load_value_i, MIN_BCD) && ge(emax, load_value_i);

    always_comb begin
        value_d    = value_q;
        load_err_d = 1'b0;
        if (load_i) begin
            if (load_ok) begin
                value_d = load_value_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_up) begin
            value_d = at_max_o ? MIN_BCD : bcd_inc(value_q);
        end else if (step_dn) begin
            value_d = at_min_o ? emax : bcd_dec(value_q);
        end else if ((CLAMP != 0) && !ge(emax, value_q)) begin
            value_d = emax;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q    <= MIN_BCD;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            load_err_q <= load_err_d;
        end
    end

    assign value_o    = value_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Directed scoreboard bench for bcd_field_counter: seconds, hours and day fields (day with and without clamp).
module tb_bcd_field_counter;

    localparam int SEC  = 0;
    localparam int HR   = 1;
    localparam int DAY  = 2;
    localparam int DAYC = 3;

    localparam int S_VAL  = 0;
    localparam int S_OVF  = 1;
    localparam int S_UNF  = 2;
    localparam int S_LERR = 3;
    localparam int S_AMAX = 4;
    localparam int S_AMIN = 5;

    logic       clk;
    logic       rst;
    logic       inc;
    logic       dec;
    logic       load;
    logic [7:0] load_value;
    logic       dyn_en;
    logic [7:0] max_v;

    logic [7:0] val  [4];
    logic       ovf  [4];
    logic       unf  [4];
    logic       lerr [4];
    logic       amax [4];
    logic       amin [4];

    typedef struct {
        string      tag;
        int         d;
        int         s;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    bcd_field_counter #(.DIGITS(2), .MIN(0), .MAX(59), .CLAMP(0)) u_sec (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .ovf_o(ovf[SEC]), .unf_o(unf[SEC]),
        .dyn_max_en_i(dyn_en), .max_i(max_v), .load_i(load), .load_value_i(load_value),
        .load_err_o(lerr[SEC]), .value_o(val[SEC]), .at_max_o(amax[SEC]), .at_min_o(amin[SEC]));

    bcd_field_counter #(.DIGITS(2), .MIN(0), .MAX(23), .CLAMP(0)) u_hr (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .ovf_o(ovf[HR]), .unf_o(unf[HR]),
        .dyn_max_en_i(dyn_en), .max_i(max_v), .load_i(load), .load_value_i(load_value),
        .load_err_o(lerr[HR]), .value_o(val[HR]), .at_max_o(amax[HR]), .at_min_o(amin[HR]));

    bcd_field_counter #(.DIGITS(2), .MIN(1), .MAX(31), .CLAMP(0)) u_day (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .ovf_o(ovf[DAY]), .unf_o(unf[DAY]),
        .dyn_max_en_i(dyn_en), .max_i(max_v), .load_i(load), .load_value_i(load_value),
        .load_err_o(lerr[DAY]), .value_o(val[DAY]), .at_max_o(amax[DAY]), .at_min_o(amin[DAY]));

    bcd_field_counter #(.DIGITS(2), .MIN(1), .MAX(31), .CLAMP(1)) u_dayc (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .ovf_o(ovf[DAYC]), .unf_o(unf[DAYC]),
        .dyn_max_en_i(dyn_en), .max_i(max_v), .load_i(load), .load_value_i(load_value),
        .load_err_o(lerr[DAYC]), .value_o(val[DAYC]), .at_max_o(amax[DAYC]), .at_min_o(amin[DAYC]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] observe(input int d, input int s);
        case (s)
            S_VAL:   return val[d];
            S_OVF:   return {7'd0, ovf[d]};
            S_UNF:   return {7'd0, unf[d]};
            S_LERR:  return {7'd0, lerr[d]};
            S_AMAX:  return {7'd0, amax[d]};
            default: return {7'd0, amin[d]};
        endcase
    endfunction

    task automatic expect_v(input string tag, input int d, input int s, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.s   = s;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic check_q();
        exp_t       e;
        logic [7:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.d, e.s);
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: dut %0d sig %0d observed %h expected %h", e.tag, e.d, e.s, obs, e.v);
            end
        end
    endtask

    task automatic set_in(input logic r, input logic i, input logic d, input logic l, input logic [7:0] lv);
        @(negedge clk);
        rst        = r;
        inc        = i;
        dec        = d;
        load       = l;
        load_value = lv;
    endtask

    task automatic comb_chk();
        #1;
        check_q();
    endtask

    task automatic clk_chk();
        @(posedge clk);
        #1;
        check_q();
    endtask

    initial begin
        rst = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = 8'h00;
        dyn_en = 1'b0; max_v = 8'h00;

        // Reset state
        set_in(1, 0, 0, 0, 8'h00);
        expect_v("rst_sec_val", SEC, S_VAL, 8'h00);
        expect_v("rst_hr_val", HR, S_VAL, 8'h00);
        expect_v("rst_day_val", DAY, S_VAL, 8'h01);
        expect_v("rst_sec_lerr", SEC, S_LERR, 8'h00);
        expect_v("rst_day_lerr", DAY, S_LERR, 8'h00);
        expect_v("rst_sec_amin", SEC, S_AMIN, 8'h01);
        expect_v("rst_sec_amax", SEC, S_AMAX, 8'h00);
        clk_chk();

        // Seconds wrap: 60 increments
        for (int i = 0; i < 60; i++) begin
            set_in(0, 1, 0, 0, 8'h00);
            expect_v("sec_step_val", SEC, S_VAL, to_bcd(i));
            expect_v("sec_step_ovf", SEC, S_OVF, (i == 59) ? 8'h01 : 8'h00);
            comb_chk();
            clk_chk();
        end
        set_in(0, 0, 0, 0, 8'h00);
        expect_v("sec_wrap_val", SEC, S_VAL, 8'h00);
        expect_v("sec_idle_ovf", SEC, S_OVF, 8'h00);
        comb_chk();

        // Hours
        set_in(0, 0, 0, 1, 8'h09);
        expect_v("hr_load09", HR, S_VAL, 8'h09);
        clk_chk();
        set_in(0, 1, 0, 0, 8'h00);
        expect_v("hr_inc09_ovf", HR, S_OVF, 8'h00);
        comb_chk();
        expect_v("hr_inc09_val", HR, S_VAL, 8'h10);
        clk_chk();
        set_in(0, 0, 0, 1, 8'h23);
        expect_v("hr_load23", HR, S_VAL, 8'h23);
        clk_chk();
        set_in(0, 1, 0, 0, 8'h00);
        expect_v("hr_inc23_ovf", HR, S_OVF, 8'h01);
        expect_v("hr_inc23_amax", HR, S_AMAX, 8'h01);
        comb_chk();
        expect_v("hr_wrap_val", HR, S_VAL, 8'h00);
        clk_chk();
        set_in(0, 0, 0, 1, 8'h24);
        expect_v("hr_load24_ovf", HR, S_OVF, 8'h00);
        comb_chk();
        expect_v("hr_load24_val", HR, S_VAL, 8'h00);
        expect_v("hr_load24_err", HR, S_LERR, 8'h01);
        clk_chk();
        set_in(0, 0, 0, 0, 8'h00);
        expect_v("hr_err_pulse_end", HR, S_LERR, 8'h00);
        clk_chk();

        // Day with runtime max 30
        set_in(0, 0, 0, 1, 8'h01);
        dyn_en = 1'b1; max_v = 8'h30;
        expect_v("day_load01", DAY, S_VAL, 8'h01);
        clk_chk();
        set_in(0, 0, 1, 0, 8'h00);
        expect_v("day_dec01_unf", DAY, S_UNF, 8'h01);
        expect_v("day_dec01_amin", DAY, S_AMIN, 8'h01);
        comb_chk();
        expect_v("day_wrap_val", DAY, S_VAL, 8'h30);
        clk_chk();
        set_in(0, 0, 1, 0, 8'h00);
        expect_v("day_dec30_unf", DAY, S_UNF, 8'h00);
        comb_chk();
        expect_v("day_dec30_val", DAY, S_VAL, 8'h29);
        clk_chk();

        // Load validation
        set_in(0, 0, 0, 1, 8'h7A);
        expect_v("day_load7a_val", DAY, S_VAL, 8'h29);
        expect_v("day_load7a_err", DAY, S_LERR, 8'h01);
        clk_chk();
        set_in(0, 0, 0, 0, 8'h00);
        expect_v("day_err_pulse_end", DAY, S_LERR, 8'h00);
        clk_chk();
        set_in(0, 0, 0, 1, 8'h59);
        dyn_en = 1'b0;
        expect_v("sec_load59", SEC, S_VAL, 8'h59);
        clk_chk();
        set_in(0, 1, 0, 1, 8'h45);
        expect_v("sec_load45_amax", SEC, S_AMAX, 8'h01);
        expect_v("sec_load45_ovf", SEC, S_OVF, 8'h00);
        comb_chk();
        expect_v("sec_load45_val", SEC, S_VAL, 8'h45);
        expect_v("sec_load45_err", SEC, S_LERR, 8'h00);
        clk_chk();

        // Clamp versus no clamp when runtime max drops below the value
        set_in(0, 0, 0, 1, 8'h31);
        dyn_en = 1'b1; max_v = 8'h31;
        expect_v("day_load31", DAY, S_VAL, 8'h31);
        expect_v("dayc_load31", DAYC, S_VAL, 8'h31);
        clk_chk();
        set_in(0, 0, 0, 0, 8'h00);
        max_v = 8'h28;
        expect_v("dayc_over_amax", DAYC, S_AMAX, 8'h01);
        comb_chk();
        expect_v("dayc_clamped", DAYC, S_VAL, 8'h28);
        expect_v("day_unclamped", DAY, S_VAL, 8'h31);
        clk_chk();
        set_in(0, 1, 0, 0, 8'h00);
        expect_v("day_over_ovf", DAY, S_OVF, 8'h01);
        comb_chk();
        expect_v("day_over_wrap", DAY, S_VAL, 8'h01);
        clk_chk();

        // inc and dec together at MIN
        set_in(0, 1, 1, 0, 8'h00);
        expect_v("day_both_ovf", DAY, S_OVF, 8'h00);
        expect_v("day_both_unf", DAY, S_UNF, 8'h00);
        comb_chk();
        expect_v("day_both_val", DAY, S_VAL, 8'h01);
        clk_chk();

        // Reset wins over a load
        set_in(1, 0, 0, 1, 8'h45);
        expect_v("rstld_day_val", DAY, S_VAL, 8'h01);
        expect_v("rstld_sec_val", SEC, S_VAL, 8'h00);
        expect_v("rstld_hr_val", HR, S_VAL, 8'h00);
        expect_v("rstld_hr_err", HR, S_LERR, 8'h00);
        clk_chk();
        set_in(0, 0, 0, 0, 8'h00);
        clk_chk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
